// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with HI/LO; results land LAT cycles after acceptance, MTHI/MTLO in one edge.
// No queueing: start is dropped while busy, so the hazard unit must stall HI/LO consumers on start|busy.
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept, done;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;

    logic               sgn, div_zero;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0]   mag_a, mag_b, divisor, uq, ur, quo, rem, res_hi, res_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Codes 0-3 (mdop[2]==0) are the multi-cycle ops; DIV/DIVU have mdop[1] set.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !mdop[2]) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = mdop[1] ? DIV_CNT : MULT_CNT;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(1)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // Signed division is done on magnitudes so the most-negative / -1 case wraps cleanly.
    always_comb begin
        sgn      = !op_q[0];
        div_zero = (b_q == '0);
        ext_a    = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
        ext_b    = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
        prod     = ext_a * ext_b;
        mag_a    = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
        mag_b    = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
        divisor  = div_zero ? WIDTH'(1) : mag_b;
        uq       = mag_a / divisor;
        ur       = mag_a % divisor;
        quo      = (sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -uq : uq;
        rem      = (sgn && a_q[WIDTH-1]) ? -ur : ur;
        res_hi   = op_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo   = op_q[1] ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            if (accept) begin
                op_q <= mdop;
                a_q  <= a;
                b_q  <= b;
            end
            if (done) begin
                if (!(op_q[1] && div_zero)) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end else if (state == IDLE && start && mdop == OP_MTHI) begin
                hi <= a;
            end else if (state == IDLE && start && mdop == OP_MTLO) begin
                lo <= a;
            end
        end
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the execute-stage ALU. Takes the same operands (rs value on a, rt value on b).
- Runs MULT/MULTU/DIV/DIVU over a configurable number of cycles, and handles single-cycle MTHI/MTLO writes.
- The hazard unit stalls any HI/LO consumer while start or busy is high.

Parameters:
- WIDTH, 32: operand width and HI/LO width.
- MULT_LAT, 5: busy cycles for MULT/MULTU (legal range ≥1).
- DIV_LAT, 10: busy cycles for DIV/DIVU (legal range ≥1).
- CNT_W, 4: counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request qualifier, sampled on a rising edge.
- mdop  in  3  operation select:
  - 0 = MULT
  - 1 = MULTU
  - 2 = DIV
  - 3 = DIVU
  - 4 = MTHI
  - 5 = MTLO
  - 6, 7 = no-op
- a  in  WIDTH  first operand (rs value).
- b  in  WIDTH  second operand (rt value).
- busy  out  1  high while a multiply or divide is in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset:
  - Asynchronous: busy=0, hi=0, lo=0, counter=0, state=IDLE.
  - Asserting reset mid-operation aborts it; the result is discarded.
- States:
  - IDLE
  - RUN: the counter counts down; the latched result is committed when the counter reaches 1.
- Request acceptance:
  - Accepted only when start=1 and busy=0 at a rising edge.
  - start while busy=1 is ignored. It does not queue, and operands, counter and HI/LO are all unaffected.
- MULT/MULTU/DIV/DIVU accepted at edge T:
  - Operands are latched at T and the result is computed from the latched values. Changing a or b after T has no effect.
  - busy=1 from after edge T through edge T+LAT. It drops at edge T+LAT, the same edge that writes hi/lo.
  - Total latency is LAT cycles. hi/lo hold their old values until edge T+LAT.
  - A new request may be accepted at edge T+LAT+1, the first edge that sees busy=0.
- MULT:
  - Signed 2*WIDTH-bit product.
  - hi = product[2W-1:W], lo = product[W-1:0].
- MULTU: same as MULT, with unsigned operands.
- DIV:
  - Signed division; quotient truncates toward zero; remainder takes the sign of the dividend.
  - lo = quotient, hi = remainder.
  - a = most negative value, b = -1: lo = a, hi = 0. No trap.
- DIVU: unsigned division; lo = quotient, hi = remainder.
- Divide by zero (b == 0, DIV or DIVU):
  - The operation still occupies DIV_LAT busy cycles.
  - hi and lo are left unchanged at completion.
- MTHI/MTLO accepted at edge T:
  - hi (or lo) = a at edge T.
  - busy stays 0; no stall cycle.
- No-op codes (6, 7) with start=1: no state change.
- Same-edge events:
  - Completion edge with a new start: the start is ignored because busy=1 at that edge.
  - Reset with start: reset wins.
- No implicit HI/LO bypass. Reads see the registered value only.

Test Plan:
- MULT: a=0xFFFFFFFE (-2), b=3, start for 1 cycle:
  - busy high for exactly 5 cycles.
  - At busy fall: hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - hi/lo unchanged at all earlier edges.
- MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV, three cases, each followed by a check 10 cycles later:
  - a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
  - DIVU a=7, b=0, with prior hi=0x11, lo=0x22 -> busy for 10 cycles, then hi=0x11, lo=0x22.
- MTHI a=0x1234 then MTLO a=0x5678, back-to-back -> hi=0x1234 after the first edge, lo=0x5678 after the second, busy never asserted.
- Start while busy:
  - Issue MULT 2*3, then DIVU 100/7 on the cycle after acceptance and with its start held through the completion edge.
  - Required: hi=0, lo=6, and DIVU ignored.
  - Re-issue DIVU after busy falls -> lo=14, hi=2.
- Reset mid-operation:
  - Assert reset 2 cycles into a DIV -> busy=0, hi=0, lo=0 immediately, with no clock edge needed.
  - After release, no late write occurs.
  - Sweep parameters WIDTH=16, MULT_LAT=1, DIV_LAT=3 and check the latencies scale accordingly.
